mem_access_stage: RTL and testbench

MEM stage of the 5-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. It runs loads and stores against an external data memory over a req/ack handshake, and stalls the front of the pipeline while an access is in flight. It presents the RegWrite/MemtoReg/ReadData/Address/rtd set that MEM/WB captures on every clock. It also flags misaligned, illegal and timed-out accesses.

---
 rtl/mem_access_stage.sv | 139 +++++++++++++
 tb/tb_mem_access_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
`timescale 1ns/1ps
// MEM pipeline stage: runs loads/stores over a req/ack data-memory handshake,
// stalls the front of the pipeline while an access is outstanding, and flags bad accesses.
module mem_access_stage #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              MemRead_MEM,
    input  logic              MemWrite_MEM,
    input  logic              RegWrite_MEM,
    input  logic              MemtoReg_MEM,
    input  logic [DATA_W-1:0] Address_MEM,
    input  logic [DATA_W-1:0] WriteData_MEM,
    input  logic [4:0]        rtd_MEM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              RegWrite_out_MEM,
    output logic              MemtoReg_out_MEM,
    output logic [DATA_W-1:0] ReadData_MEM,
    output logic [DATA_W-1:0] Address_out_MEM,
    output logic [4:0]        rtd_out_MEM,
    output logic              stall_MEM,
    output logic              access_err
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    state_t            state, next_state;
    logic [7:0]        wait_cnt;
    logic              abort;
    logic [DATA_W-1:0] rdata_cap;
    logic              any_op;
    logic              legal_op;
    logic              timed_out;

    assign any_op    = MemRead_MEM | MemWrite_MEM;
    assign legal_op  = (MemRead_MEM ^ MemWrite_MEM) && (Address_MEM[1:0] == 2'b00);
    // An ack arriving on the final allowed WAIT cycle wins over the timeout.
    assign timed_out = (wait_cnt == LAST_WAIT) && !mem_ack;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (legal_op) next_state = WAIT;
            WAIT:    if (mem_ack || timed_out) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_cap <= '0;
            wait_cnt  <= '0;
            abort     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (legal_op) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite_MEM;
                        mem_addr  <= Address_MEM;
                        mem_wdata <= WriteData_MEM;
                        wait_cnt  <= '0;
                        abort     <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        rdata_cap <= mem_we ? '0 : mem_rdata;
                    end else if (timed_out) begin
                        mem_req   <= 1'b0;
                        rdata_cap <= '0;
                        abort     <= 1'b1;
                    end else begin
                        wait_cnt  <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    wait_cnt <= '0;
                    abort    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign MemtoReg_out_MEM = MemtoReg_MEM;
    assign Address_out_MEM  = Address_MEM;
    assign rtd_out_MEM      = rtd_MEM;

    always_comb begin
        RegWrite_out_MEM = RegWrite_MEM;
        ReadData_MEM     = '0;
        stall_MEM        = 1'b0;
        access_err       = 1'b0;
        case (state)
            IDLE: begin
                if (any_op) begin
                    RegWrite_out_MEM = 1'b0;
                    stall_MEM        = legal_op;
                    access_err       = !legal_op;
                end
            end
            WAIT: begin
                RegWrite_out_MEM = 1'b0;
                stall_MEM        = 1'b1;
            end
            DONE: begin
                ReadData_MEM     = rdata_cap;
                RegWrite_out_MEM = RegWrite_MEM && !abort;
                access_err       = abort;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
`timescale 1ns/1ps
// Bench for mem_access_stage: directed table, reset-abort sequence and random
// operations checked against a transaction-level model of the stage.
module tb_mem_access_stage;

    localparam int unsigned T = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead_MEM = 1'b0, MemWrite_MEM = 1'b0, RegWrite_MEM = 1'b0, MemtoReg_MEM = 1'b0;
    logic [31:0] Address_MEM = '0, WriteData_MEM = '0, mem_rdata = '0;
    logic [4:0]  rtd_MEM = '0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, RegWrite_out_MEM, MemtoReg_out_MEM, stall_MEM, access_err;
    logic [31:0] mem_addr, mem_wdata, ReadData_MEM, Address_out_MEM;
    logic [4:0]  rtd_out_MEM;

    int unsigned checks = 0;
    int unsigned errors = 0;

    mem_access_stage #(.DATA_W(32), .TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset),
        .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
        .RegWrite_MEM(RegWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM),
        .Address_MEM(Address_MEM), .WriteData_MEM(WriteData_MEM), .rtd_MEM(rtd_MEM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .RegWrite_out_MEM(RegWrite_out_MEM), .MemtoReg_out_MEM(MemtoReg_out_MEM),
        .ReadData_MEM(ReadData_MEM), .Address_out_MEM(Address_out_MEM),
        .rtd_out_MEM(rtd_out_MEM), .stall_MEM(stall_MEM), .access_err(access_err)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ack_cycle: WAIT cycle (1-based) in which mem_ack is raised, 0 = never.
    typedef struct {
        logic        rd, wr, rw, m2r;
        logic [31:0] addr, wdata, rdata;
        logic [4:0]  rtd;
        int unsigned ack_cycle;
        int unsigned exp_wait;
        logic        exp_err, exp_rw;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outcome of one instruction from the stage's access rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic ok;
        r.exp_wait = 0; r.exp_err = 1'b0; r.exp_rw = v.rw; r.exp_rdata = '0;
        if (v.rd || v.wr) begin
            if ((v.rd && v.wr) || v.addr[1:0] != 2'b00) begin
                r.exp_err = 1'b1;
                r.exp_rw  = 1'b0;
            end else begin
                ok = (v.ack_cycle != 0) && (v.ack_cycle <= T);
                r.exp_wait  = ok ? v.ack_cycle : T;
                r.exp_err   = !ok;
                r.exp_rw    = v.rw && ok;
                r.exp_rdata = (ok && v.rd) ? v.rdata : 32'h0;
            end
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic rd, input logic wr, input logic rw, input logic m2r,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [4:0] rtd, input int unsigned ackc,
                                input logic [31:0] rdata, input int unsigned ew,
                                input logic ee, input logic erw, input logic [31:0] erd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.rw = rw; v.m2r = m2r; v.addr = addr; v.wdata = wdata;
        v.rtd = rtd; v.ack_cycle = ackc; v.rdata = rdata;
        v.exp_wait = ew; v.exp_err = ee; v.exp_rw = erw; v.exp_rdata = erd;
        return v;
    endfunction

    task automatic check_pass(input vec_t v);
        chk("memtoreg_pass", {31'b0, MemtoReg_out_MEM}, {31'b0, v.m2r});
        chk("addr_pass", Address_out_MEM, v.addr);
        chk("rtd_pass", {27'b0, rtd_out_MEM}, {27'b0, v.rtd});
    endtask

    // Drives one instruction from the EX/MEM side and checks every cycle it occupies.
    task automatic run_op(input vec_t v);
        @(posedge clock); #1;
        MemRead_MEM = v.rd; MemWrite_MEM = v.wr; RegWrite_MEM = v.rw; MemtoReg_MEM = v.m2r;
        Address_MEM = v.addr; WriteData_MEM = v.wdata; rtd_MEM = v.rtd;
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        @(negedge clock);
        check_pass(v);
        chk("idle_req", {31'b0, mem_req}, 32'h0);
        chk("idle_rdata", ReadData_MEM, 32'h0);
        if (v.exp_wait == 0) begin
            chk("idle_stall", {31'b0, stall_MEM}, 32'h0);
            chk("idle_err", {31'b0, access_err}, {31'b0, v.exp_err});
            chk("idle_regwrite", {31'b0, RegWrite_out_MEM}, {31'b0, v.exp_rw});
        end else begin
            chk("idle_stall", {31'b0, stall_MEM}, 32'h1);
            chk("idle_err", {31'b0, access_err}, 32'h0);
            chk("idle_regwrite", {31'b0, RegWrite_out_MEM}, 32'h0);
            for (int k = 1; k <= int'(v.exp_wait); k++) begin
                @(posedge clock); #1;
                mem_ack   = (k == int'(v.ack_cycle));
                mem_rdata = mem_ack ? v.rdata : $urandom;
                @(negedge clock);
                chk("wait_req", {31'b0, mem_req}, 32'h1);
                chk("wait_we", {31'b0, mem_we}, {31'b0, v.wr});
                chk("wait_addr", mem_addr, v.addr);
                chk("wait_wdata", mem_wdata, v.wdata);
                chk("wait_stall", {31'b0, stall_MEM}, 32'h1);
                chk("wait_regwrite", {31'b0, RegWrite_out_MEM}, 32'h0);
                chk("wait_err", {31'b0, access_err}, 32'h0);
            end
            @(posedge clock); #1;
            mem_ack = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            @(negedge clock);
            check_pass(v);
            chk("done_req", {31'b0, mem_req}, 32'h0);
            chk("done_stall", {31'b0, stall_MEM}, 32'h0);
            chk("done_rdata", ReadData_MEM, v.exp_rdata);
            chk("done_regwrite", {31'b0, RegWrite_out_MEM}, {31'b0, v.exp_rw});
            chk("done_err", {31'b0, access_err}, {31'b0, v.exp_err});
        end
    endtask

    vec_t table_v[$];

    initial begin
        // load, store with ack on the last allowed cycle, misaligned, timeout, back-to-back, no-ops
        table_v.push_back(mk(1, 0, 1, 1, 32'h10, 32'h0, 5'd5, 1, 32'hDEADBEEF, 1, 0, 1, 32'hDEADBEEF));
        table_v.push_back(mk(0, 1, 0, 0, 32'h20, 32'h12345678, 5'd0, 4, 32'hFFFF0000, 4, 0, 0, 32'h0));
        table_v.push_back(mk(1, 0, 1, 1, 32'h13, 32'h0, 5'd7, 1, 32'h0, 0, 1, 0, 32'h0));
        table_v.push_back(mk(1, 0, 1, 1, 32'h40, 32'h0, 5'd9, 0, 32'hAAAA5555, 4, 1, 0, 32'h0));
        table_v.push_back(mk(1, 0, 1, 1, 32'h0, 32'h0, 5'd1, 1, 32'h11111111, 1, 0, 1, 32'h11111111));
        table_v.push_back(mk(1, 0, 1, 1, 32'h4, 32'h0, 5'd2, 1, 32'h22222222, 1, 0, 1, 32'h22222222));
        table_v.push_back(mk(1, 1, 1, 0, 32'h8, 32'h5, 5'd3, 1, 32'h0, 0, 1, 0, 32'h0));
        table_v.push_back(mk(0, 0, 1, 0, 32'hCAFEF00D, 32'h0, 5'd31, 0, 32'h0, 0, 0, 1, 32'h0));
        table_v.push_back(mk(0, 1, 1, 0, 32'h32, 32'h77, 5'd4, 1, 32'h0, 0, 1, 0, 32'h0));

        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_req", {31'b0, mem_req}, 32'h0);
        chk("rst_we", {31'b0, mem_we}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_stall", {31'b0, stall_MEM}, 32'h0);
        chk("rst_rdata", ReadData_MEM, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // reset while a load waits for its ack
        @(posedge clock); #1;
        MemRead_MEM = 1'b1; Address_MEM = 32'h100; RegWrite_MEM = 1'b1; rtd_MEM = 5'd6;
        @(posedge clock); #1;
        @(negedge clock);
        chk("mid_req", {31'b0, mem_req}, 32'h1);
        #1;
        MemRead_MEM = 1'b0;
        reset = 1'b0;
        #1;
        chk("abort_req", {31'b0, mem_req}, 32'h0);
        chk("abort_addr", mem_addr, 32'h0);
        chk("abort_stall", {31'b0, stall_MEM}, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        mem_ack = 1'b1; mem_rdata = 32'hBAADF00D;
        @(negedge clock);
        chk("stray_stall", {31'b0, stall_MEM}, 32'h0);
        chk("stray_rdata", ReadData_MEM, 32'h0);
        chk("stray_err", {31'b0, access_err}, 32'h0);
        chk("stray_regwrite", {31'b0, RegWrite_out_MEM}, 32'h1);
        @(posedge clock); #1;
        mem_ack = 1'b0;
        @(negedge clock);
        chk("stray_req", {31'b0, mem_req}, 32'h0);
        chk("stray_rdata2", ReadData_MEM, 32'h0);

        foreach (table_v[i]) run_op(table_v[i]);

        for (int n = 0; n < 60; n++) begin
            vec_t v;
            v.rd  = 1'($urandom_range(0, 1));
            v.wr  = ($urandom_range(0, 9) == 0) ? 1'b1 : (!v.rd && $urandom_range(0, 1) == 1);
            v.rw  = 1'($urandom_range(0, 1));
            v.m2r = 1'($urandom_range(0, 1));
            v.addr = $urandom;
            if ($urandom_range(0, 3) != 0) v.addr[1:0] = 2'b00;
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.rtd = 5'($urandom_range(0, 31));
            v.ack_cycle = $urandom_range(0, 6);
            run_op(model(v));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
